idct_line_stream: RTL and testbench
===================================

// Module: idct_line_stream
// PURPOSE
//  Parametrised 1-D inverse DCT line engine. Supports 4-, 8- and 16-point HEVC integer transforms.
//  Accepts N coefficients serially over a valid/ready stream and emits N residual samples serially.
//  Output stream has backpressure.
//  Sits between the coefficient dequantiser and the transpose buffer. One instance handles rows or columns.
// PARAMETERS
//  IN_W   16  signed input coefficient width
//  OUT_W  17  signed output sample width
//  SHIFT  12  right-shift applied after accumulation (rounded)
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  mode       in   2      00=4-pt, 01=8-pt, 10=16-pt, 11=reserved
//  in_valid   in   1      in_data valid
//  in_ready   out  1      block can accept in_data
//  in_data    in   IN_W   coefficient x[n], n=0..N-1 in order
//  out_valid  out  1      out_data valid
//  out_ready  in   1      downstream accepts out_data
//  out_data   out  OUT_W  sample y[k], k=0..N-1 in order
//  out_last   out  1      high with y[N-1]
//  mode_err   out  1      one-cycle pulse when reserved mode is latched
// BEHAVIOUR
//  - Reset values: in_ready=1, out_valid=0, out_data=0, out_last=0, mode_err=0.
//  - Reset clears the FSM, the sample buffer and the counters. Reset mid-block discards the block.
//  - FSM states: LOAD and DRAIN.
//    - LOAD: in_ready=1. Each in_valid&in_ready beat writes buf[cnt] and increments cnt.
//    - Mode is latched on the beat with cnt==0. Changes to mode during the block are ignored.
//    - Reserved mode 11 is processed as 4-pt, and mode_err pulses on the cycle after that beat.
//    - On the beat with cnt==N-1: go to DRAIN and set k=0. in_ready drops the next cycle.
//  - DRAIN: in_ready=0 (single buffer). out_valid is registered.
//    - out_valid rises the cycle after the last input beat (latency 1 cycle).
//    - out_data = y[k]. out_valid&out_ready advances k.
//    - out_data, out_valid and out_last hold stable while out_ready=0.
//    - The beat with k==N-1 (out_last=1) returns the FSM to LOAD. in_ready=1 on the next cycle.
//    - out_valid=0 from that cycle onward.
//    - An input beat in the same cycle as the final output beat is not accepted (in_ready=0).
//  - Arithmetic: y[k] = (sum_n C[n][k]*x[n] + 2^(SHIFT-1)) >>> SHIFT.
//    - Accumulator width is IN_W+8+4 bits, signed. >>> is arithmetic (floor).
//    - C is the 16x16 HEVC matrix; row0 is all 64; row1 = 90 87 80 70 57 43 25 9 -9 ... -90.
//    - 8-pt uses rows 2n, cols 0..7 of the 16x16 matrix. 4-pt uses rows 4n, cols 0..3.
//    - Coefficients are a constant function of (n,k); no RAM.
//    - One y[k] is computed per cycle by N parallel constant multipliers over the buffer.
//    - Unused buffer entries are masked to 0 for N<16.
//  - Output narrowing from the accumulator to OUT_W is governed by the CONFIGURATION section.
//  - Counters wrap only through the FSM. cnt and k never exceed N-1.
// CONFIGURATION
//  IDCT_LINE_SAT_EN
//   - defined: the result is clipped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//   - undefined: the result is truncated to the low OUT_W bits (two's-complement wrap).
// TESTING
//  1. 4-pt, x=[4096,0,0,0] -> y=64,64,64,64; out_last on the 4th beat; out_valid 1 cycle after the last input.
//  2. 8-pt, x=[4096,4096,0,0,0,0,0,0] -> y0=153, y7=-25.
//  3. 16-pt, x1=4096, others 0 -> y0=90, y15=-90; 16 output beats.
//  4. 8-pt, out_ready=0 for 3 cycles at k=2.
//     -> out_data/out_last stay stable; in_ready=0; all 8 values correct and in order.
//  5. OUT_W=12, 16-pt, all x=32767 -> y0=7520 pre-clip.
//     -> 2047 with IDCT_LINE_SAT_EN, -672 without.
//  6. Assert rst_n=0 at k=3 in DRAIN -> outputs immediately at reset values.
//     A fresh 4-pt block after release gives scenario 1 results. Also: mode=11 -> mode_err pulse, 4-pt results.

Source files
------------

// File: rtl/idct_line_stream.sv
// idct_line_stream
//   1-D inverse DCT line engine for the 4-, 8- and 16-point HEVC integer
//   transforms. Coefficients arrive serially, are collected in a 16-entry
//   buffer, and the N residual samples leave serially, one dot product per
//   cycle, with valid/ready backpressure on both sides.
//
// Parameters
//   IN_W   signed input coefficient width
//   OUT_W  signed output sample width
//   SHIFT  rounded right shift applied after accumulation
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   mode       00=4-pt, 01=8-pt, 10=16-pt, 11=reserved (run as 4-pt)
//   in_valid   / in_ready   / in_data    coefficient stream x[0..N-1]
//   out_valid  / out_ready  / out_data   sample stream y[0..N-1]
//   out_last   marks y[N-1]
//   mode_err   one-cycle pulse after a block is started in reserved mode
//
// Build option
//   IDCT_LINE_SAT_EN  defined: clip results to the OUT_W signed range;
//                     undefined: keep the low OUT_W bits (wrap).

module idct_line_stream #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 17,
    parameter int SHIFT = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_last,
    output logic                    mode_err
);

    localparam int ACC_W = IN_W + 8 + 4;
    localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) << (SHIFT - 1);
`ifdef IDCT_LINE_SAT_EN
    localparam int SAT_MAX_I = (1 << (OUT_W - 1)) - 1;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(SAT_MAX_I);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-SAT_MAX_I - 1);
`endif

    typedef enum logic {
        LOAD  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t r_state, w_state_next;

    logic signed [IN_W-1:0]  r_buf [16];
    logic [3:0]              r_cnt;
    logic [3:0]              r_k;
    logic [1:0]              r_mode;
    logic                    r_out_valid;
    logic                    r_out_last;
    logic                    r_mode_err;
    logic signed [OUT_W-1:0] r_out_data;

    logic                    w_in_fire;
    logic                    w_out_fire;
    logic                    w_in_last;
    logic                    w_out_final;
    logic [1:0]              w_mode_in;
    logic [1:0]              w_mode_cur;
    logic [3:0]              w_nm1;
    logic [3:0]              w_kidx;
    logic signed [IN_W-1:0]  w_x [16];
    logic signed [ACC_W-1:0] w_acc;
    logic signed [ACC_W-1:0] w_sh;
    logic signed [OUT_W-1:0] w_y;

    // Last index of the block for a (reserved-free) mode.
    function automatic logic [3:0] f_nm1(input logic [1:0] m);
        case (m)
            2'b01:   return 4'd7;
            2'b10:   return 4'd15;
            default: return 4'd3;
        endcase
    endfunction

    // Row step into the 16x16 matrix: 8-pt uses rows 2n, 4-pt rows 4n.
    function automatic int unsigned f_stride(input logic [1:0] m);
        case (m)
            2'b01:   return 2;
            2'b10:   return 1;
            default: return 4;
        endcase
    endfunction

    // HEVC 16x16 matrix entry C[r][c] ~ 64*sqrt(2)*cos((2c+1)*r*pi/32).
    // The angle index is folded into 0..16 and looked up in a 17-entry table.
    function automatic logic signed [7:0] f_coef(input int unsigned r, input int unsigned c);
        int unsigned      p;
        logic             neg;
        logic signed [7:0] mag;
        p = ((2 * c + 1) * r) % 64;
        if (p > 32) p = 64 - p;
        neg = (p > 16);
        if (neg) p = 32 - p;
        case (p)
            0:       mag = 8'sd64;
            1:       mag = 8'sd90;
            2:       mag = 8'sd89;
            3:       mag = 8'sd87;
            4:       mag = 8'sd83;
            5:       mag = 8'sd80;
            6:       mag = 8'sd75;
            7:       mag = 8'sd70;
            8:       mag = 8'sd64;
            9:       mag = 8'sd57;
            10:      mag = 8'sd50;
            11:      mag = 8'sd43;
            12:      mag = 8'sd36;
            13:      mag = 8'sd25;
            14:      mag = 8'sd18;
            15:      mag = 8'sd9;
            default: mag = 8'sd0;
        endcase
        return neg ? -mag : mag;
    endfunction

    // Handshake and block-size decode. On the first beat of a block the
    // incoming mode is used directly because it is not latched yet.
    always_comb begin
        w_mode_in   = (mode == 2'b11) ? 2'b00 : mode;
        w_mode_cur  = (r_state == LOAD && r_cnt == 4'd0) ? w_mode_in : r_mode;
        w_nm1       = f_nm1(w_mode_cur);
        w_in_fire   = (r_state == LOAD) && in_valid;
        w_out_fire  = (r_state == DRAIN) && r_out_valid && out_ready;
        w_in_last   = w_in_fire && (r_cnt == w_nm1);
        w_out_final = w_out_fire && (r_k == w_nm1);
        w_kidx      = (r_state == DRAIN) ? (r_k + 4'd1) : 4'd0;
    end

    // Dot product for output index w_kidx. The beat being written this cycle
    // is bypassed into the buffer view so y[0] can be registered on the last
    // input beat, giving the one-cycle output latency.
    always_comb begin
        w_acc = '0;
        for (int unsigned n = 0; n < 16; n++) begin
            w_x[n] = (w_in_fire && 32'(r_cnt) == n) ? in_data : r_buf[n];
            if (n <= 32'(w_nm1)) begin
                w_acc = w_acc + ACC_W'(w_x[n]) *
                        ACC_W'(f_coef(n * f_stride(w_mode_cur), 32'(w_kidx)));
            end
        end
        w_sh = (w_acc + RND) >>> SHIFT;
`ifdef IDCT_LINE_SAT_EN
        if (w_sh > SAT_MAX) begin
            w_y = SAT_MAX[OUT_W-1:0];
        end else if (w_sh < SAT_MIN) begin
            w_y = SAT_MIN[OUT_W-1:0];
        end else begin
            w_y = OUT_W'(w_sh);
        end
`else
        w_y = OUT_W'(w_sh);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        case (r_state)
            LOAD: begin
                in_ready = 1'b1;
                if (w_in_last) w_state_next = DRAIN;
            end
            DRAIN: begin
                if (w_out_final) w_state_next = LOAD;
            end
            default: w_state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 16; i++) begin
                r_buf[i] <= '0;
            end
            r_cnt       <= '0;
            r_k         <= '0;
            r_mode      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_mode_err  <= 1'b0;
        end else begin
            r_mode_err <= w_in_fire && (r_cnt == 4'd0) && (mode == 2'b11);

            if (w_in_fire) begin
                r_buf[r_cnt] <= in_data;
                if (r_cnt == 4'd0) r_mode <= w_mode_in;
                if (w_in_last) begin
                    r_cnt       <= '0;
                    r_k         <= '0;
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_y;
                    r_out_last  <= 1'b0;
                end else begin
                    r_cnt <= r_cnt + 4'd1;
                end
            end

            if (w_out_fire) begin
                if (w_out_final) begin
                    r_k         <= '0;
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                end else begin
                    r_k        <= w_kidx;
                    r_out_data <= w_y;
                    r_out_last <= (w_kidx == w_nm1);
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign mode_err  = r_mode_err;

endmodule

// File: tb/tb_idct_line_stream.sv
// Directed testbench for idct_line_stream. A default-width instance and an
// OUT_W=12 instance share the input stimulus; the narrow one exercises the
// output narrowing (clip with IDCT_LINE_SAT_EN, wrap without).

module tb_idct_line_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic [1:0]         mode;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic signed [16:0] out_data;
    logic               out_last;
    logic               mode_err;

    logic               in_ready12;
    logic               out_valid12;
    logic signed [11:0] out_data12;
    logic               out_last12;
    logic               mode_err12;

    int n_vec = 0;
    int n_err = 0;

    logic signed [15:0] xv [16];
    int                 yv [16];

    idct_line_stream u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .mode_err  (mode_err)
    );

    idct_line_stream #(.OUT_W(12)) u_dut12 (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready12),
        .in_data   (in_data),
        .out_valid (out_valid12),
        .out_ready (out_ready),
        .out_data  (out_data12),
        .out_last  (out_last12),
        .mode_err  (mode_err12)
    );

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Feed n coefficients from xv; mode m0 on the first beat, m_rest after.
    task automatic send(input int n, input logic [1:0] m0, input logic [1:0] m_rest);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = xv[i];
            mode     = (i == 0) ? m0 : m_rest;
            @(negedge clk);
            check($sformatf("in_ready_load[%0d]", i), in_ready, 1);
            if (i > 0)
                check($sformatf("mode_err[%0d]", i), mode_err,
                      (i == 1 && m0 == 2'b11) ? 1 : 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    // Collect n samples against yv; optional 3-cycle stall at stall_k and an
    // input beat offered alongside the final output beat.
    task automatic recv(input int n, input int stall_k, input bit poke_last);
        out_ready = 1'b1;
        for (int k = 0; k < n; k++) begin
            if (k == stall_k) begin
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_valid", out_valid, 1);
                    check($sformatf("stall_data[%0d]", k), out_data, yv[k]);
                    check("stall_last", out_last, 0);
                    check("stall_in_ready", in_ready, 0);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
            if (poke_last && k == n - 1) begin
                in_valid = 1'b1;
                in_data  = 16'sd12345;
            end
            @(negedge clk);
            check($sformatf("out_valid[%0d]", k), out_valid, 1);
            check($sformatf("out_data[%0d]", k), out_data, yv[k]);
            check($sformatf("out_last[%0d]", k), out_last, (k == n - 1) ? 1 : 0);
            check($sformatf("in_ready_drain[%0d]", k), in_ready, 0);
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_data  = '0;
        end
        @(negedge clk);
        check("valid_after", out_valid, 0);
        check("last_after", out_last, 0);
        check("in_ready_after", in_ready, 1);
        @(posedge clk); #1;
    endtask

    task automatic set_x(input int v0, input int v1, input int vall);
        for (int i = 0; i < 16; i++) xv[i] = 16'(vall);
        xv[0] = 16'(v0);
        xv[1] = 16'(v1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp12;
        rst_n     = 1'b0;
        mode      = 2'b00;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_mode_err", mode_err, 0);
        check("rst_in_ready12", in_ready12, 1);
        check("rst_mode_err12", mode_err12, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 4-pt DC; input offered with the final output beat must be refused
        set_x(4096, 0, 0);
        yv[0:3] = '{64, 64, 64, 64};
        send(4, 2'b00, 2'b00);
        recv(4, -1, 1'b1);

        // 4-pt rows 4n, negative rounding: C[4][k] - 2
        set_x(-100, 4096, 0);
        yv[0:3] = '{81, 34, -38, -85};
        send(4, 2'b00, 2'b00);
        recv(4, -1, 1'b0);

        // 8-pt, mode changed mid-block must be ignored
        set_x(4096, 4096, 0);
        yv[0:7] = '{153, 139, 114, 82, 46, 14, -11, -25};
        send(8, 2'b01, 2'b00);
        recv(8, -1, 1'b0);

        // 16-pt, x1 only: row 1 of the matrix
        set_x(0, 4096, 0);
        yv = '{90, 87, 80, 70, 57, 43, 25, 9, -9, -25, -43, -57, -70, -80, -87, -90};
        send(16, 2'b10, 2'b01);
        recv(16, -1, 1'b0);

        // 16-pt full scale: column-0 sum 940 -> 7520, narrowed on OUT_W=12
`ifdef IDCT_LINE_SAT_EN
        exp12 = 2047;
`else
        exp12 = -672;
`endif
        set_x(32767, 32767, 32767);
        send(16, 2'b10, 2'b10);
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k == 0) begin
                check("fullscale_y0", out_data, 7520);
                check("narrow_y0", out_data12, exp12);
            end
            check($sformatf("fs_valid[%0d]", k), out_valid, 1);
            check($sformatf("fs_last[%0d]", k), out_last, (k == 15) ? 1 : 0);
            check($sformatf("fs_valid12[%0d]", k), out_valid12, 1);
            check($sformatf("fs_last12[%0d]", k), out_last12, (k == 15) ? 1 : 0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("fs_valid_after", out_valid, 0);
        @(posedge clk); #1;

        // 8-pt with stall at k=2; buffer entries 8..15 still hold 32767
        set_x(4096, 4096, 0);
        yv[0:7] = '{153, 139, 114, 82, 46, 14, -11, -25};
        send(8, 2'b01, 2'b01);
        recv(8, 2, 1'b0);

        // Reset while y[3] is presented in DRAIN
        set_x(4096, 4096, 0);
        send(8, 2'b01, 2'b01);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("pre_rst_data[%0d]", k), out_data, yv[k]);
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_out_last", out_last, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_mode_err", mode_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        set_x(4096, 0, 0);
        yv[0:3] = '{64, 64, 64, 64};
        send(4, 2'b00, 2'b00);
        recv(4, -1, 1'b0);

        // Reserved mode: 4-pt results, mode_err pulse, later mode ignored
        set_x(4096, 0, 0);
        yv[0:3] = '{64, 64, 64, 64};
        send(4, 2'b11, 2'b10);
        recv(4, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
